branch_target_predictor: RTL and testbench

Fetch-stage branch predictor: a direct-mapped branch target buffer with 2-bit saturating counters. It supplies `Predict`/`Prediction` to the PC update logic in the I stage. It carries each prediction alongside its instruction through R into C, where it compares the prediction against the resolved outcome. From that comparison it drives `PredictionCorrect_C` and trains the table.

---
 rtl/branch_target_predictor_if.sv | 36 +++
 rtl/branch_target_predictor.sv | 117 +++++++++++
 tb/tb_branch_target_predictor.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_target_predictor_if.sv
// Fetch-side lookup and C-stage resolution signals between the
// pipeline control (master) and the branch target predictor (slave).
`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

interface branch_target_predictor_if #(
   parameter int W = `BIT_COUNT
);
   logic [W-1:0] PC_I;
   logic         StallI;
   logic         StallR;
   logic         StallC;
   logic         FlushR;
   logic         FlushC;
   logic         BranchValid_C;
   logic         Taken_C;
   logic [W-1:0] Target_C;
   logic [W-1:0] PC_C;
   logic         Predict;
   logic [W-1:0] Prediction;
   logic         PredictionCorrect_C;
   logic         Mispredict_C;

   modport master (
      output PC_I, StallI, StallR, StallC, FlushR, FlushC,
      output BranchValid_C, Taken_C, Target_C, PC_C,
      input  Predict, Prediction, PredictionCorrect_C, Mispredict_C
   );

   modport slave (
      input  PC_I, StallI, StallR, StallC, FlushR, FlushC,
      input  BranchValid_C, Taken_C, Target_C, PC_C,
      output Predict, Prediction, PredictionCorrect_C, Mispredict_C
   );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit counters; prediction metadata rides
// I->R->C and is checked against the resolved outcome in C.
`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

module branch_target_predictor #(
   parameter int ENTRIES = 16
) (
   input logic                       clk,
   input logic                       reset,
   branch_target_predictor_if.slave  bus
);
   localparam int W   = `BIT_COUNT;
   localparam int IDX = $clog2(ENTRIES);
   localparam int TW  = W - IDX - 2;

   logic [ENTRIES-1:0] valid;
   logic [TW-1:0]      tag_q [ENTRIES];
   logic [W-1:0]       tgt_q [ENTRIES];
   logic [1:0]         ctr_q [ENTRIES];

   logic [IDX-1:0] idx_i;
   logic [IDX-1:0] idx_c;
   logic [TW-1:0]  tag_i;
   logic [TW-1:0]  tag_c;
   logic           hit_i;
   logic           hit_c;
   logic           pred_i;
   logic [W-1:0]   ptgt_i;

   logic           pt_r;
   logic [W-1:0]   ptg_r;
   logic           pt_c;
   logic [W-1:0]   ptg_c;

   logic           correct;
   logic           train;
   logic [1:0]     ctr_cur;
   logic [1:0]     ctr_up;
   logic [1:0]     ctr_dn;

   logic           unused;
   assign unused = ^{bus.StallI, bus.PC_I[1:0], bus.PC_C[1:0]};

   assign idx_i = bus.PC_I[IDX+1:2];
   assign tag_i = bus.PC_I[W-1:IDX+2];
   assign idx_c = bus.PC_C[IDX+1:2];
   assign tag_c = bus.PC_C[W-1:IDX+2];

   assign hit_i  = valid[idx_i] && (tag_q[idx_i] == tag_i);
   assign hit_c  = valid[idx_c] && (tag_q[idx_c] == tag_c);
   assign pred_i = hit_i && ctr_q[idx_i][1];
   assign ptgt_i = hit_i ? tgt_q[idx_i] : '0;

   assign bus.Predict    = pred_i;
   assign bus.Prediction = ptgt_i;

   // Target only matters when the branch was actually taken.
   assign correct = bus.BranchValid_C
                 && (pt_c == bus.Taken_C)
                 && (!bus.Taken_C || (ptg_c == bus.Target_C));

   assign bus.PredictionCorrect_C = correct;
   assign bus.Mispredict_C        = bus.BranchValid_C && !correct;

   assign train   = bus.BranchValid_C && !bus.StallC && !bus.FlushC;
   assign ctr_cur = ctr_q[idx_c];
   assign ctr_up  = (ctr_cur == 2'd3) ? 2'd3 : ctr_cur + 2'd1;
   assign ctr_dn  = (ctr_cur == 2'd0) ? 2'd0 : ctr_cur - 2'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= '0;
         pt_r  <= 1'b0;
         ptg_r <= '0;
         pt_c  <= 1'b0;
         ptg_c <= '0;
      end else begin
         if (bus.FlushR) begin
            pt_r  <= 1'b0;
            ptg_r <= '0;
         end else if (!bus.StallR) begin
            pt_r  <= pred_i;
            ptg_r <= ptgt_i;
         end
         if (bus.FlushC) begin
            pt_c  <= 1'b0;
            ptg_c <= '0;
         end else if (!bus.StallC) begin
            pt_c  <= pt_r;
            ptg_c <= ptg_r;
         end
         if (train && !hit_c && bus.Taken_C) begin
            valid[idx_c] <= 1'b1;
         end
      end
   end

   // Table payload carries no reset; valid bits gate its use.
   always_ff @(posedge clk) begin
      if (!reset && train) begin
         if (hit_c) begin
            if (bus.Taken_C) begin
               ctr_q[idx_c] <= ctr_up;
               tgt_q[idx_c] <= bus.Target_C;
            end else begin
               ctr_q[idx_c] <= ctr_dn;
            end
         end else if (bus.Taken_C) begin
            tag_q[idx_c] <= tag_c;
            tgt_q[idx_c] <= bus.Target_C;
            ctr_q[idx_c] <= 2'd2;
         end
      end
   end
endmodule

// File: tb/tb_branch_target_predictor.sv
// Randomized and directed checks of the branch target predictor
// against a table-and-slot reference model.
`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

module tb_branch_target_predictor;
   localparam int W = `BIT_COUNT;
   localparam int N = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   branch_target_predictor_if #(.W(W)) bus();

   branch_target_predictor #(.ENTRIES(N)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [W-1:0] obs,
                      input logic [W-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   typedef struct {
      bit           tk;
      logic [W-1:0] tgt;
      logic [W-1:0] pc;
   } slot_t;

   bit           m_v   [N];
   longint       m_tag [N];
   logic [W-1:0] m_tgt [N];
   int           m_ctr [N];
   slot_t        s_r;
   slot_t        s_c;

   logic [W-1:0] d_pci, d_tgt, d_pcc;
   bit d_bv, d_tk, d_sr, d_sc, d_fr, d_fc, d_rst;

   function automatic int ix(logic [W-1:0] pc);
      return int'((pc / 4) % N);
   endfunction

   function automatic longint tg(logic [W-1:0] pc);
      return longint'(pc / (4 * N));
   endfunction

   function automatic bit mhit(logic [W-1:0] pc);
      return m_v[ix(pc)] && m_tag[ix(pc)] == tg(pc);
   endfunction

   function automatic bit e_pred();
      return mhit(d_pci) && m_ctr[ix(d_pci)] >= 2;
   endfunction

   function automatic logic [W-1:0] e_tgt();
      return mhit(d_pci) ? m_tgt[ix(d_pci)] : '0;
   endfunction

   function automatic bit e_ok();
      return d_bv && (s_c.tk == d_tk) && (!d_tk || s_c.tgt == d_tgt);
   endfunction

   task automatic put(input logic [W-1:0] pci, input bit bv,
                      input bit tk, input logic [W-1:0] tgt,
                      input logic [W-1:0] pcc, input bit sr,
                      input bit sc, input bit fr, input bit fc,
                      input bit rst);
      @(negedge clk);
      d_pci = pci; d_bv = bv; d_tk = tk; d_tgt = tgt; d_pcc = pcc;
      d_sr = sr; d_sc = sc; d_fr = fr; d_fc = fc; d_rst = rst;
      reset = rst;
      bus.PC_I = pci; bus.BranchValid_C = bv; bus.Taken_C = tk;
      bus.Target_C = tgt; bus.PC_C = pcc; bus.StallI = sr;
      bus.StallR = sr; bus.StallC = sc; bus.FlushR = fr;
      bus.FlushC = fc;
      #1;
      if (!rst) begin
         chk("predict", W'(bus.Predict), W'(e_pred()));
         chk("prediction", bus.Prediction, e_tgt());
         chk("correct", W'(bus.PredictionCorrect_C), W'(e_ok()));
         chk("mispredict", W'(bus.Mispredict_C), W'(d_bv && !e_ok()));
      end
   endtask

   task automatic tick();
      slot_t nr, nc, z;
      int i;
      z = '{tk: 1'b0, tgt: '0, pc: '0};
      nr = d_fr ? z : (!d_sr ? '{tk: e_pred(), tgt: e_tgt(), pc: d_pci} : s_r);
      nc = d_fc ? z : (!d_sc ? s_r : s_c);
      @(posedge clk);
      if (d_rst) begin
         for (int k = 0; k < N; k++) m_v[k] = 1'b0;
         s_r = z;
         s_c = z;
      end else begin
         if (d_bv && !d_sc && !d_fc) begin
            i = ix(d_pcc);
            if (mhit(d_pcc)) begin
               if (d_tk) begin
                  m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                  m_tgt[i] = d_tgt;
               end else begin
                  m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
               end
            end else if (d_tk) begin
               m_v[i] = 1'b1;
               m_tag[i] = tg(d_pcc);
               m_tgt[i] = d_tgt;
               m_ctr[i] = 2;
            end
         end
         s_r = nr;
         s_c = nc;
      end
   endtask

   task automatic fetch(input logic [W-1:0] pci);
      put(pci, 0, 0, '0, '0, 0, 0, 0, 0, 0);
   endtask

   task automatic res(input logic [W-1:0] pcc, input bit tk,
                      input logic [W-1:0] tgt);
      put('0, 1, tk, tgt, pcc, 0, 0, 0, 0, 0);
   endtask

   initial begin
      logic [W-1:0] pc, pcc, tgt;
      bit bv, tk, sr, sc, fr, fc, rst;
      s_r = '{tk: 1'b0, tgt: '0, pc: '0};
      s_c = s_r;

      repeat (2) begin
         put('0, 0, 0, '0, '0, 0, 0, 0, 0, 1); tick();
      end
      fetch(32'h40);
      chk("rst_predict", W'(bus.Predict), '0);
      chk("rst_prediction", bus.Prediction, '0);
      chk("rst_correct", W'(bus.PredictionCorrect_C), '0);
      tick();

      res(32'h40, 1, 32'h100);
      chk("alloc_mis", W'(bus.Mispredict_C), 1);
      tick();
      fetch(32'h40);
      chk("alloc_pred", W'(bus.Predict), 1);
      chk("alloc_tgt", bus.Prediction, 32'h100);
      tick();

      res(32'h40, 0, '0); tick();
      fetch(32'h40);
      chk("hyst_ctr1", W'(bus.Predict), 0);
      tick();
      repeat (2) begin res(32'h40, 1, 32'h100); tick(); end
      fetch(32'h40);
      chk("hyst_ctr3", W'(bus.Predict), 1);
      tick();
      repeat (5) begin res(32'h40, 0, '0); tick(); end
      res(32'h40, 1, 32'h100); tick();
      fetch(32'h40);
      chk("hyst_floor", W'(bus.Predict), 0);
      tick();
      repeat (2) begin res(32'h40, 1, 32'h100); tick(); end

      fetch(32'h440);
      chk("alias_miss", W'(bus.Predict), 0);
      tick();
      res(32'h440, 1, 32'h200); tick();
      fetch(32'h40);
      chk("alias_evict", W'(bus.Predict), 0);
      tick();
      fetch(32'h440);
      chk("alias_tgt", bus.Prediction, 32'h200);
      tick();

      res(32'h40, 1, 32'h100); tick();
      fetch(32'h40); tick();
      fetch('0); tick();
      repeat (3) begin
         put('0, 1, 1, 32'h100, 32'h40, 1, 1, 0, 0, 0);
         chk("stall_ok", W'(bus.PredictionCorrect_C), 1);
         tick();
      end
      res(32'h40, 1, 32'h100);
      chk("stall_ok_last", W'(bus.PredictionCorrect_C), 1);
      tick();

      fetch(32'h40); tick();
      fetch('0); tick();
      res(32'h40, 1, 32'h180);
      chk("wrong_tgt", W'(bus.Mispredict_C), 1);
      tick();
      fetch(32'h40);
      chk("new_tgt", bus.Prediction, 32'h180);
      tick();

      put(32'h40, 0, 0, '0, '0, 0, 0, 1, 0, 0); tick();
      fetch('0); tick();
      res(32'h40, 1, 32'h180);
      chk("flush_bubble", W'(bus.Mispredict_C), 1);
      tick();

      put(32'h40, 1, 1, 32'h200, 32'h440, 0, 0, 0, 0, 0);
      chk("coll_old", bus.Prediction, 32'h180);
      tick();
      fetch(32'h40);
      chk("coll_new", W'(bus.Predict), 0);
      tick();

      for (int n = 0; n < 800; n++) begin
         pc  = (W'($urandom_range(0, 2)) << 6) |
               (W'($urandom_range(0, 3)) << 2);
         bv  = ($urandom_range(0, 9) < 6);
         tk  = ($urandom_range(0, 9) < 6);
         tgt = W'($urandom_range(1, 6)) << 6;
         if ($urandom_range(0, 3) != 0 && s_c.pc != 0) begin
            pcc = s_c.pc;
            if ($urandom_range(0, 1) == 1 && s_c.tk) tgt = s_c.tgt;
         end else begin
            pcc = (W'($urandom_range(0, 2)) << 6) |
                  (W'($urandom_range(0, 3)) << 2);
         end
         sr  = ($urandom_range(0, 9) == 0);
         sc  = ($urandom_range(0, 9) == 0);
         fr  = ($urandom_range(0, 11) == 0);
         fc  = ($urandom_range(0, 11) == 0);
         rst = ($urandom_range(0, 199) == 0);
         put(pc, bv, tk, tgt, pcc, sr, sc, fr, fc, rst);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
